// File: rtl/csel_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
interface csel_adder_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_Valid;
    logic             out_Ready;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             in_C;
    logic             in_Sub;
    logic             out_Valid;
    logic             in_Ready;
    logic [WIDTH-1:0] out_S;
    logic             out_C;
    logic             out_V;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_Valid, in_A, in_B, in_C, in_Sub, in_Ready,
        input  out_Ready, out_Valid, out_S, out_C, out_V
    );

    // Adder side.
    modport slave (
        input  in_Valid, in_A, in_B, in_C, in_Sub, in_Ready,
        output out_Ready, out_Valid, out_S, out_C, out_V
    );
endinterface

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure.
// Each stage resolves BLOCK*BPS sum bits; the stage carry and the still
// unconsumed operand bits travel forward so all bits leave together.
module csel_adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 4,
    parameter int unsigned BPS   = 2
) (
    input  logic             in_CLK,
    input  logic             in_RST,
    csel_adder_pipe_if.slave bus
);
    localparam int unsigned SW  = BLOCK * BPS;
    localparam int unsigned LAT = WIDTH / SW;

    // Per-stage pipeline registers; index k is the output of stage k.
    logic             vld_q [LAT];
    logic             vld_d [LAT];
    logic             cry_q [LAT];
    logic             cry_d [LAT];
    logic             am_q  [LAT];
    logic             am_d  [LAT];
    logic             bm_q  [LAT];
    logic             bm_d  [LAT];
    logic [WIDTH-1:0] s_q   [LAT];
    logic [WIDTH-1:0] s_d   [LAT];
    logic [WIDTH-1:0] ra_q  [LAT];
    logic [WIDTH-1:0] ra_d  [LAT];
    logic [WIDTH-1:0] rb_q  [LAT];
    logic [WIDTH-1:0] rb_d  [LAT];
    logic             v_q;
    logic             v_d;

    logic             advance;
    logic [WIDTH-1:0] beff;
    logic             cin0;

    // Plain ripple over one block.
    function automatic logic [BLOCK:0] ripple(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             ci
    );
        logic [BLOCK-1:0] s;
        logic             c;
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // One stage worth of blocks; the least significant block of the whole
    // adder ripples directly from cin, every other block selects between
    // precomputed carry-0 and carry-1 results.
    function automatic logic [SW:0] csel_seg(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          ci,
        input logic          lsb_seg
    );
        logic [SW-1:0] s;
        logic          c;
        logic [BLOCK:0] r0;
        logic [BLOCK:0] r1;
        s  = '0;
        c  = ci;
        r0 = '0;
        r1 = '0;
        for (int unsigned j = 0; j < BPS; j++) begin
            if (lsb_seg && (j == 0)) begin
                r0 = ripple(a[j*BLOCK +: BLOCK], b[j*BLOCK +: BLOCK], c);
                s[j*BLOCK +: BLOCK] = r0[BLOCK-1:0];
                c = r0[BLOCK];
            end else begin
                r0 = ripple(a[j*BLOCK +: BLOCK], b[j*BLOCK +: BLOCK], 1'b0);
                r1 = ripple(a[j*BLOCK +: BLOCK], b[j*BLOCK +: BLOCK], 1'b1);
                s[j*BLOCK +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                c = c ? r1[BLOCK] : r0[BLOCK];
            end
        end
        return {c, s};
    endfunction

    assign advance = !vld_q[LAT-1] || bus.in_Ready;
    assign beff    = bus.in_B ^ {WIDTH{bus.in_Sub}};
    assign cin0    = bus.in_C ^ bus.in_Sub;

    // Next-state for every stage: resolve this stage's slice, skew the rest.
    always_comb begin : p_next
        logic [SW-1:0]    sa;
        logic [SW-1:0]    sb;
        logic             ci;
        logic [WIDTH-1:0] s_lo;
        logic [SW:0]      r;
        int unsigned      prv;
        sa   = '0;
        sb   = '0;
        ci   = 1'b0;
        s_lo = '0;
        r    = '0;
        prv  = 0;
        v_d  = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) begin
            vld_d[k] = 1'b0;
            cry_d[k] = 1'b0;
            am_d[k]  = 1'b0;
            bm_d[k]  = 1'b0;
            s_d[k]   = '0;
            ra_d[k]  = '0;
            rb_d[k]  = '0;
        end
        for (int unsigned k = 0; k < LAT; k++) begin
            prv = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                sa       = bus.in_A[SW-1:0];
                sb       = beff[SW-1:0];
                ci       = cin0;
                s_lo     = '0;
                ra_d[k]  = bus.in_A >> SW;
                rb_d[k]  = beff >> SW;
                am_d[k]  = bus.in_A[WIDTH-1];
                bm_d[k]  = beff[WIDTH-1];
                vld_d[k] = bus.in_Valid;
            end else begin
                sa       = ra_q[prv][SW-1:0];
                sb       = rb_q[prv][SW-1:0];
                ci       = cry_q[prv];
                s_lo     = s_q[prv];
                ra_d[k]  = ra_q[prv] >> SW;
                rb_d[k]  = rb_q[prv] >> SW;
                am_d[k]  = am_q[prv];
                bm_d[k]  = bm_q[prv];
                vld_d[k] = vld_q[prv];
            end
            r        = csel_seg(sa, sb, ci, k == 0);
            cry_d[k] = r[SW];
            s_d[k]   = s_lo | (WIDTH'(r[SW-1:0]) << (k * SW));
        end
        v_d = (am_d[LAT-1] == bm_d[LAT-1]) && (s_d[LAT-1][WIDTH-1] != am_d[LAT-1]);
    end

    // Stage registers: reset clears everything, otherwise shift on advance.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
                cry_q[k] <= 1'b0;
                am_q[k]  <= 1'b0;
                bm_q[k]  <= 1'b0;
                s_q[k]   <= '0;
                ra_q[k]  <= '0;
                rb_q[k]  <= '0;
            end
            v_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                vld_q[k] <= vld_d[k];
                cry_q[k] <= cry_d[k];
                am_q[k]  <= am_d[k];
                bm_q[k]  <= bm_d[k];
                s_q[k]   <= s_d[k];
                ra_q[k]  <= ra_d[k];
                rb_q[k]  <= rb_d[k];
            end
            v_q <= v_d;
        end
    end

    assign bus.out_Ready = advance;
    assign bus.out_Valid = vld_q[LAT-1];
    assign bus.out_S     = s_q[LAT-1];
    assign bus.out_C     = cry_q[LAT-1];
    assign bus.out_V     = v_q;

endmodule
